// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial frame detector.
package seq_det_pkg;
  typedef enum logic [1:0] {
    HUNT    = 2'b00,
    PAYLOAD = 2'b01,
    DONE    = 2'b10
  } state_t;

  localparam int              DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;
endpackage

// File: rtl/seq_pattern_window.sv
// Sliding sync-pattern window with a fill counter so stale/reset contents never match.
module seq_pattern_window #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bitIn,
  output logic match
);
  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] window;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] nextWin;

  assign nextWin = {window[PAT_W-2:0], bitIn};
  // Fill must reach PAT_W counting the bit being shifted in right now.
  assign match = en && (nextWin == PATTERN) && (fill >= FW'(PAT_W - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      window <= '0;
      fill   <= '0;
    end else if (en) begin
      window <= nextWin;
      if (fill != FW'(PAT_W)) fill <= fill + 1'b1;
    end
  end
endmodule

// File: rtl/seq_frame_detector.sv
// Hunts for a sync pattern, forwards len payload bits, then pulses frame_done.
module seq_frame_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             SerIn,
  input  logic [LEN_W-1:0] len,
  output logic             SerOut,
  output logic             SerOutValid,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);
  state_t           state;
  logic [LEN_W-1:0] bitCnt;
  logic [LEN_W-1:0] lenQ;
  logic             match;

  seq_pattern_window #(.PAT_W(PAT_W), .PATTERN(PATTERN)) uWin (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == DONE),
    .en    (clk_en && (state == HUNT)),
    .bitIn (SerIn),
    .match (match)
  );

  // Payload passes straight through with no added latency.
  assign SerOutValid = clk_en && (state == PAYLOAD);
  assign SerOut      = SerOutValid & SerIn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      bitCnt     <= '0;
      lenQ       <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        HUNT: begin
          if (match) begin
            lenQ   <= len;
            bitCnt <= '0;
            busy   <= 1'b1;
            if (len != '0) begin
              state <= PAYLOAD;
            end else begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (clk_en) begin
            bitCnt <= bitCnt + 1'b1;
            if (bitCnt == lenQ - 1'b1) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= HUNT;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          frame_cnt  <= frame_cnt + 1'b1;
        end
        default: begin
          state      <= HUNT;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_frame_detector.sv
// Vector table, directed corner sequences and random traffic against a queue-based reference.
module tb_seq_frame_detector;
  localparam int         PW  = 4;
  localparam logic [3:0] PAT = 4'b1011;

  logic       clk = 1'b0, rst = 1'b0, clk_en = 1'b0, SerIn = 1'b0;
  logic [3:0] len = '0;
  logic       SerOut, SerOutValid, frame_done, busy;
  logic [7:0] frame_cnt;
  logic       zSerOut, zSerOutValid, zDone, zBusy;
  logic [7:0] zCnt;

  always #5 clk = ~clk;

  seq_frame_detector dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .SerIn(SerIn), .len(len),
    .SerOut(SerOut), .SerOutValid(SerOutValid), .frame_done(frame_done),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  seq_frame_detector #(.PATTERN(4'b0000)) dutZ (
    .clk(clk), .rst(rst), .clk_en(clk_en), .SerIn(SerIn), .len(len),
    .SerOut(zSerOut), .SerOutValid(zSerOutValid), .frame_done(zDone),
    .busy(zBusy), .frame_cnt(zCnt)
  );

  int nCmp = 0, nBad = 0;

  // Reference: bits heard while hunting, payload bits still owed, done flag, frame total.
  bit huntQ[$];
  int remaining = 0;
  bit inDone = 0;
  int frames = 0;
  bit mValid = 0;

  typedef struct {
    bit         r, ce, si;
    logic [3:0] l;
    logic [11:0] exp;  // {SerOutValid, SerOut, frame_done, busy, frame_cnt}
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] modelOut(input bit ce, input bit si);
    bit v;
    v = (remaining > 0) && ce;
    return {v, v & si, inDone, (remaining > 0) || inDone, 8'(frames)};
  endfunction

  task automatic modelStep(input bit r, input bit ce, input bit si, input logic [3:0] l);
    bit hit;
    if (r) begin
      huntQ.delete(); remaining = 0; inDone = 0; frames = 0; mValid = 1;
    end else if (inDone) begin
      inDone = 0; frames++; huntQ.delete();
    end else if (remaining > 0) begin
      if (ce) begin
        remaining--;
        if (remaining == 0) inDone = 1;
      end
    end else if (ce) begin
      huntQ.push_back(si);
      if (huntQ.size() > PW) void'(huntQ.pop_front());
      hit = (huntQ.size() == PW);
      if (hit) for (int i = 0; i < PW; i++) if (huntQ[i] != PAT[PW-1-i]) hit = 0;
      if (hit) begin
        remaining = int'(l);
        if (l == 0) inDone = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit ce, input bit si, input logic [3:0] l,
                     input string nm = "model", input bit useExp = 0,
                     input logic [11:0] exp = '0);
    @(negedge clk);
    rst = r; clk_en = ce; SerIn = si; len = l;
    #1;
    if (mValid) chk(nm, {SerOutValid, SerOut, frame_done, busy, frame_cnt}, modelOut(ce, si));
    if (useExp) chk({nm, "_tbl"}, {SerOutValid, SerOut, frame_done, busy, frame_cnt}, exp);
    @(posedge clk);
    modelStep(r, ce, si, l);
  endtask

  task automatic sendBits(input logic [31:0] bits, input int n, input logic [3:0] l,
                          input int gap, input string nm);
    for (int i = n - 1; i >= 0; i--) begin
      repeat (gap) cyc(0, 0, 0, l, nm);
      cyc(0, 1, bits[i], l, nm);
    end
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 4'd3, 12'h000};
    tbl[1] = '{0, 1, 1, 4'd3, 12'h000};
    tbl[2] = '{0, 1, 0, 4'd3, 12'h000};
    tbl[3] = '{0, 1, 1, 4'd3, 12'h000};
    tbl[4] = '{0, 1, 1, 4'd3, 12'h000};
    tbl[5] = '{0, 1, 1, 4'd3, 12'hD00};
    tbl[6] = '{0, 1, 0, 4'd3, 12'h900};
    tbl[7] = '{0, 1, 1, 4'd3, 12'hD00};
    tbl[8] = '{0, 0, 0, 4'd3, 12'h300};
    tbl[9] = '{0, 0, 0, 4'd3, 12'h001};

    cyc(1, 0, 0, 0);
    #1 chk("reset_state", {SerOutValid, SerOut, frame_done, busy, frame_cnt}, 0);

    // Basic frame, len=3, stream 1011 101.
    for (int i = 0; i < 10; i++)
      cyc(tbl[i].r, tbl[i].ce, tbl[i].si, tbl[i].l, "basic", 1, tbl[i].exp);

    // Overlapping prefix: 101011 matches on the 6th bit.
    cyc(1, 0, 0, 2);
    sendBits(6'b101011, 6, 2, 0, "overlap");
    #1 chk("overlap_busy", busy, 1);
    sendBits(2'b10, 2, 2, 0, "overlap");
    repeat (3) cyc(0, 0, 0, 2, "overlap");

    // Strobe every third cycle.
    cyc(1, 0, 0, 3);
    sendBits(7'b1011101, 7, 3, 2, "sparse");
    repeat (4) cyc(0, 0, 0, 3, "sparse");
    #1 chk("sparse_cnt", frame_cnt, 1);

    // Empty frame.
    cyc(1, 0, 0, 0);
    sendBits(4'b1011, 4, 0, 0, "len0");
    #1 chk("len0_done", frame_done, 1);
    repeat (2) cyc(0, 1, 0, 0, "len0");
    #1 chk("len0_cnt", frame_cnt, 1);

    // Reset in the middle of a payload.
    sendBits(4'b1011, 4, 5, 0, "rstmid");
    sendBits(2'b11, 2, 5, 0, "rstmid");
    cyc(1, 1, 1, 5, "rstmid");
    #1 chk("rstmid_state", {busy, frame_done, frame_cnt}, 0);
    repeat (3) cyc(0, 0, 0, 5, "rstmid");

    // All-zero pattern needs a full window of zeros after reset.
    cyc(1, 0, 0, 2);
    sendBits(0, 3, 2, 0, "zpat");
    #1 chk("zpat_3zeros", zBusy, 0);
    sendBits(0, 1, 2, 0, "zpat");
    #1 chk("zpat_4zeros", zBusy, 1);

    // Back-to-back len=1 frames: counter wraps.
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 256; k++) begin
      sendBits(4'b1011, 4, 1, 0, "wrap");
      sendBits(1, 1, 1, 0, "wrap");
      cyc(0, 0, 0, 1, "wrap");
      if (k == 0) begin
        #1 chk("wrap_first", frame_cnt, 1);
      end
    end
    #1 chk("wrap_zero", frame_cnt, 0);

    // A strobe during DONE must not seed the next pattern.
    sendBits(4'b1011, 4, 1, 0, "donebit");
    sendBits(1, 1, 1, 0, "donebit");
    cyc(0, 1, 1, 1, "donebit");
    sendBits(3'b011, 3, 1, 0, "donebit");
    #1 chk("done_discard", busy, 0);

    // Random traffic.
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit r, ce, si;
      logic [3:0] l;
      r  = ($urandom % 300) == 0;
      ce = ($urandom % 4) != 0;
      si = 1'($urandom);
      l  = (($urandom % 8) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 4));
      cyc(r, ce, si, l, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
